cache_bank_ctrl: RTL and testbench
==================================

Name: cache_bank_ctrl

Overview:
- Access controller for one cache way of four 32-bit banks; each bank is four byte-wide simple dual-port RAMs, 256 lines deep.
- Shares the common bank index and the per-byte write enables between two requesters:
  - the CPU load/store port, one word per access;
  - the refill port, a 4-beat line fill from the memory side.
- Sequences the line refill and aligns load responses to the RAM's 1-cycle read latency.
- Sits between the cache main FSM / LSU and the bank array.

Parameters:
- BANK_NUM, 4, banks per line (one 32-bit word each)
- INDEX_AW, 8, line index width (256 lines)
- DATA_WIDTH, 32, word width
- BYTE_NUM, 4, byte-wide RAMs per bank (DATA_WIDTH/8)

Ports:
- clk  in  1  single clock for controller and banks
- rst_n  in  1  reset; synchronous, active-low
- cpu_req_valid_i  in  1  CPU request valid
- cpu_req_ready_o  out  1  CPU request accepted when valid&ready
- cpu_req_we_i  in  1  1=store, 0=load
- cpu_req_index_i  in  INDEX_AW  line index
- cpu_req_bank_i  in  2  word (bank) select within line
- cpu_req_wstrb_i  in  BYTE_NUM  store byte strobes
- cpu_req_wdata_i  in  DATA_WIDTH  store data
- cpu_rsp_valid_o  out  1  load data valid
- cpu_rsp_data_o  out  DATA_WIDTH  load data
- refill_start_i  in  1  1-cycle pulse, begin line fill at refill_index_i
- refill_index_i  in  INDEX_AW  line index of fill
- refill_valid_i  in  1  refill beat valid
- refill_ready_o  out  1  refill beat accepted when valid&ready
- refill_data_i  in  DATA_WIDTH  refill beat data, beat k goes to bank k
- refill_done_o  out  1  1-cycle pulse after last beat written
- busy_o  out  1  refill in progress
- bank_index_o  out  INDEX_AW  shared read/write index to all banks
- bank_wr_en_o  out  BANK_NUM*BYTE_NUM  per-bank per-byte write enables, bank b at [b*4+:4]
- bank_wr_data_o  out  DATA_WIDTH  write data broadcast to all banks
- bank_rd_data_i  in  BANK_NUM*DATA_WIDTH  registered RAM outputs, bank b at [b*32+:32]

Behaviour:
- FSM states: IDLE, REFILL. 2-bit beat counter; 8-bit latched refill index.
- Reset (rst_n=0 at clk edge): state=IDLE, counter=0.
  - Outputs held low: cpu_rsp_valid_o=0, refill_done_o=0, busy_o=0, refill_ready_o=0.
  - cpu_rsp_data_o=0 (no response pending); bank_wr_en_o=0.
  - cpu_req_ready_o=0 during reset.
- IDLE:
  - refill_start_i=1: latch index, counter=0, go REFILL.
    - cpu_req_ready_o=0 that cycle; refill wins over a simultaneous CPU request.
  - Otherwise cpu_req_ready_o=1; bank_index_o=cpu_req_index_i.
  - Accepted store: bank_wr_en_o[bank*4+:4]=wstrb, all others 0; bank_wr_data_o=wdata.
    - wstrb=0 is accepted with no write. Stores produce no response.
  - Accepted load: bank_wr_en_o=0. Capture bank select into a 1-cycle pipeline register.
    - Next cycle: cpu_rsp_valid_o=1, cpu_rsp_data_o=bank_rd_data_i[sel*32+:32].
    - Back-to-back loads sustain 1/cycle.
- REFILL:
  - busy_o=1, cpu_req_ready_o=0, refill_ready_o=1, bank_index_o=latched index.
  - On refill_valid_i: bank_wr_en_o[cnt*4+:4]=4'hF, bank_wr_data_o=refill_data_i, cnt++.
  - refill_valid_i=0: no write, state held; bubbles allowed between beats.
  - Beat 3 accepted: go IDLE; refill_done_o=1 in the following cycle.
    - A CPU request may be accepted in that same cycle.
    - A load there to the refilled index returns the new data, since the write committed at the prior edge.
- Pending load response when refill starts: the response is still delivered in the next cycle with the pre-refill data.
- refill_start_i while in REFILL is ignored. This is a protocol violation and is flagged by an assertion.
- refill_valid_i outside REFILL is ignored, with refill_ready_o=0.
- Reset mid-refill: return to IDLE, no refill_done_o pulse, partial line left in RAM. The cache FSM must invalidate the tag.
- No address hazard exists: only one requester drives index/write per cycle, and a write is visible to reads issued in later cycles.

Decomposition:
- Shared defines: CACHE_INDEX_AW, DATA_WIDTH, RAM_NUM (byte RAMs per bank), BANK_NUM, FSM state encodings (ST_IDLE, ST_REFILL), and the WR_PORT_ENABLE / RD_PORT_ENABLE constants.
- Single module; no sub-module. The bank instances are owned by the parent way module.

Test Plan:
- Store then load: store idx=0x12, bank=2, wstrb=4'b0101, wdata=0xAABBCCDD → bank_wr_en_o=16'h0500. Load idx=0x12, bank=2 → rsp_valid one cycle later, data=0x??BB??DD; unwritten bytes keep their prior contents.
- Refill: start idx=0x40, beats 0x11111111..0x44444444 with one bubble after beat 1 → wr_en 0x000F,0x00F0,0x0F00,0xF000. done pulse one cycle after beat 3. Loads of banks 0-3 at 0x40 return the four beats.
- Simultaneous refill_start_i and cpu_req_valid_i in IDLE → cpu_req_ready_o=0, busy_o=1 next cycle. CPU request is accepted in the refill_done_o cycle.
- Back-to-back loads to 4 different indices → 4 consecutive rsp_valid cycles with correct data, 1-cycle latency each.
- rst_n=0 after 2 refill beats → IDLE, busy_o=0, no refill_done_o pulse. A new refill of 4 beats completes normally.
- Load accepted in the cycle before refill_start_i at the same index → response carries the old data; a post-refill load carries the new data.

Source files
------------

// File: rtl/cache_bank_ctrl_pkg.sv
// Shared constants, state encodings and helpers for the cache bank access controller.
package cache_bank_ctrl_pkg;

    localparam int unsigned CACHE_INDEX_AW = 8;
    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned RAM_NUM        = DATA_WIDTH / 8;
    localparam int unsigned BANK_NUM       = 4;
    localparam int unsigned BANK_SEL_W     = 2;
    localparam int unsigned WR_EN_W        = BANK_NUM * RAM_NUM;

    // Byte RAM port enables are tied active by the parent way module.
    localparam logic WR_PORT_ENABLE = 1'b1;
    localparam logic RD_PORT_ENABLE = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } state_e;

    typedef logic [BANK_SEL_W-1:0] bank_sel_t;

    typedef struct packed {
        logic      valid;
        bank_sel_t sel;
    } rsp_pipe_t;

    // Place a byte strobe into the flat per-bank write-enable vector.
    function automatic logic [WR_EN_W-1:0] bank_byte_en(input bank_sel_t bank,
                                                        input logic [RAM_NUM-1:0] strb);
        logic [WR_EN_W-1:0] en;
        en = '0;
        en[32'(bank) * RAM_NUM +: RAM_NUM] = strb;
        return en;
    endfunction

endpackage

// File: rtl/cache_bank_ctrl.sv
// Arbitrates the shared bank index/write port between CPU accesses and line refill,
// and aligns load responses to the registered RAM read latency.
module cache_bank_ctrl
    import cache_bank_ctrl_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cpu_req_valid_i,
    output logic                           cpu_req_ready_o,
    input  logic                           cpu_req_we_i,
    input  logic [CACHE_INDEX_AW-1:0]      cpu_req_index_i,
    input  logic [BANK_SEL_W-1:0]          cpu_req_bank_i,
    input  logic [RAM_NUM-1:0]             cpu_req_wstrb_i,
    input  logic [DATA_WIDTH-1:0]          cpu_req_wdata_i,
    output logic                           cpu_rsp_valid_o,
    output logic [DATA_WIDTH-1:0]          cpu_rsp_data_o,
    input  logic                           refill_start_i,
    input  logic [CACHE_INDEX_AW-1:0]      refill_index_i,
    input  logic                           refill_valid_i,
    output logic                           refill_ready_o,
    input  logic [DATA_WIDTH-1:0]          refill_data_i,
    output logic                           refill_done_o,
    output logic                           busy_o,
    output logic [CACHE_INDEX_AW-1:0]      bank_index_o,
    output logic [WR_EN_W-1:0]             bank_wr_en_o,
    output logic [DATA_WIDTH-1:0]          bank_wr_data_o,
    input  logic [BANK_NUM*DATA_WIDTH-1:0] bank_rd_data_i
);

    state_e                      state_q, state_d;
    logic [BANK_SEL_W-1:0]       cnt_q, cnt_d;
    logic [CACHE_INDEX_AW-1:0]   idx_q, idx_d;
    rsp_pipe_t                   rsp_q, rsp_d;
    logic                        done_q, done_d;

    // State and pipeline registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            rsp_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rsp_q   <= rsp_d;
            done_q  <= done_d;
        end
    end

    // Next state and bank port steering; refill start wins over a CPU request.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        idx_d           = idx_q;
        rsp_d.valid     = 1'b0;
        rsp_d.sel       = rsp_q.sel;
        done_d          = 1'b0;
        cpu_req_ready_o = 1'b0;
        refill_ready_o  = 1'b0;
        busy_o          = 1'b0;
        bank_index_o    = cpu_req_index_i;
        bank_wr_en_o    = '0;
        bank_wr_data_o  = cpu_req_wdata_i;

        case (state_q)
            ST_IDLE: begin
                if (refill_start_i) begin
                    idx_d   = refill_index_i;
                    cnt_d   = '0;
                    state_d = ST_REFILL;
                end else begin
                    cpu_req_ready_o = 1'b1;
                    if (cpu_req_valid_i) begin
                        if (cpu_req_we_i) begin
                            bank_wr_en_o = bank_byte_en(cpu_req_bank_i, cpu_req_wstrb_i);
                        end else begin
                            rsp_d.valid = 1'b1;
                            rsp_d.sel   = cpu_req_bank_i;
                        end
                    end
                end
            end
            ST_REFILL: begin
                busy_o         = 1'b1;
                refill_ready_o = 1'b1;
                bank_index_o   = idx_q;
                bank_wr_data_o = refill_data_i;
                if (refill_valid_i) begin
                    bank_wr_en_o = bank_byte_en(cnt_q, {RAM_NUM{1'b1}});
                    cnt_d        = cnt_q + 2'd1;
                    if (cnt_q == 2'(BANK_NUM - 1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase

        // Nothing is granted or written while reset is applied.
        if (!rst_n) begin
            cpu_req_ready_o = 1'b0;
            refill_ready_o  = 1'b0;
            busy_o          = 1'b0;
            bank_wr_en_o    = '0;
        end
    end

    assign cpu_rsp_valid_o = rsp_q.valid & rst_n;
    assign cpu_rsp_data_o  = cpu_rsp_valid_o
                           ? bank_rd_data_i[32'(rsp_q.sel) * DATA_WIDTH +: DATA_WIDTH]
                           : '0;
    assign refill_done_o   = done_q & rst_n;

    // A second start during a fill is dropped by the FSM; flag it as a protocol error.
    refill_start_while_busy: assert property (
        @(posedge clk) disable iff (!rst_n) !(state_q == ST_REFILL && refill_start_i)
    ) else $error("refill_start_i asserted while a refill is in progress");

endmodule

// File: tb/tb_cache_bank_ctrl.sv
// Self-checking bench for cache_bank_ctrl with a byte-enabled bank RAM model and load scoreboard.
module tb_cache_bank_ctrl;
    import cache_bank_ctrl_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         cpu_req_valid_i;
    logic         cpu_req_ready_o;
    logic         cpu_req_we_i;
    logic [7:0]   cpu_req_index_i;
    logic [1:0]   cpu_req_bank_i;
    logic [3:0]   cpu_req_wstrb_i;
    logic [31:0]  cpu_req_wdata_i;
    logic         cpu_rsp_valid_o;
    logic [31:0]  cpu_rsp_data_o;
    logic         refill_start_i;
    logic [7:0]   refill_index_i;
    logic         refill_valid_i;
    logic         refill_ready_o;
    logic [31:0]  refill_data_i;
    logic         refill_done_o;
    logic         busy_o;
    logic [7:0]   bank_index_o;
    logic [15:0]  bank_wr_en_o;
    logic [31:0]  bank_wr_data_o;
    logic [127:0] bank_rd_data_i;

    cache_bank_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cpu_req_valid_i (cpu_req_valid_i),
        .cpu_req_ready_o (cpu_req_ready_o),
        .cpu_req_we_i    (cpu_req_we_i),
        .cpu_req_index_i (cpu_req_index_i),
        .cpu_req_bank_i  (cpu_req_bank_i),
        .cpu_req_wstrb_i (cpu_req_wstrb_i),
        .cpu_req_wdata_i (cpu_req_wdata_i),
        .cpu_rsp_valid_o (cpu_rsp_valid_o),
        .cpu_rsp_data_o  (cpu_rsp_data_o),
        .refill_start_i  (refill_start_i),
        .refill_index_i  (refill_index_i),
        .refill_valid_i  (refill_valid_i),
        .refill_ready_o  (refill_ready_o),
        .refill_data_i   (refill_data_i),
        .refill_done_o   (refill_done_o),
        .busy_o          (busy_o),
        .bank_index_o    (bank_index_o),
        .bank_wr_en_o    (bank_wr_en_o),
        .bank_wr_data_o  (bank_wr_data_o),
        .bank_rd_data_i  (bank_rd_data_i)
    );

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        we;
        logic [7:0]  idx;
        logic [1:0]  bank;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [15:0] exp_en;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[12];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          done_cnt = 0;
    int          exp_done = 0;
    logic [31:0] ram    [4][256];
    logic [31:0] shadow [4][256];
    logic [127:0] rd_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int b, input int i);
        return {8'h5A, 8'(b), 8'(i), ~8'(i)};
    endfunction

    // Bank array stand-in: registered read, byte-enabled write, read-before-write.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            rd_q[b*32 +: 32] <= ram[b][bank_index_o];
            for (int j = 0; j < 4; j++) begin
                if (bank_wr_en_o[b*4 + j])
                    ram[b][bank_index_o][j*8 +: 8] <= bank_wr_data_o[j*8 +: 8];
            end
        end
    end
    assign bank_rd_data_i = rd_q;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor: pop the scoreboard whenever the DUT presents load data.
    always @(negedge clk) begin
        if (rst_n && cpu_rsp_valid_o) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected: got data %0h with no load outstanding", cpu_rsp_data_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_data", cpu_rsp_data_o, e.data);
                chk("rsp_cycle", cyc, e.cyc);
            end
        end
        if (rst_n && refill_done_o) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_op(input logic we, input logic [7:0] idx, input logic [1:0] bank,
                          input logic [3:0] strb, input logic [31:0] wdata,
                          input logic [15:0] exp_en);
        cpu_req_valid_i = 1'b1;
        cpu_req_we_i    = we;
        cpu_req_index_i = idx;
        cpu_req_bank_i  = bank;
        cpu_req_wstrb_i = strb;
        cpu_req_wdata_i = wdata;
        #3;
        chk("cpu_ready", cpu_req_ready_o, 1'b1);
        chk("cpu_index", bank_index_o, idx);
        chk("cpu_wr_en", bank_wr_en_o, exp_en);
        if (we) begin
            chk("cpu_wr_data", bank_wr_data_o, wdata);
            for (int j = 0; j < 4; j++)
                if (strb[j]) shadow[bank][idx][j*8 +: 8] = wdata[j*8 +: 8];
        end else begin
            sb.push_back('{data: shadow[bank][idx], cyc: cyc + 1});
        end
        step();
        cpu_req_valid_i = 1'b0;
    endtask

    // Line fill of nbeats beats (beat k = beat0*(k+1)); a full fill ends inside the done cycle.
    task automatic refill(input logic [7:0] idx, input logic [31:0] beat0,
                          input int nbeats, input int bubble_after);
        refill_start_i = 1'b1;
        refill_index_i = idx;
        #3;
        chk("start_cpu_ready", cpu_req_ready_o, 1'b0);
        chk("start_wr_en", bank_wr_en_o, 16'h0);
        step();
        refill_start_i = 1'b0;
        refill_index_i = ~idx;
        for (int k = 0; k < nbeats; k++) begin
            logic [31:0] d;
            d = beat0 * 32'(k + 1);
            refill_valid_i = 1'b1;
            refill_data_i  = d;
            #3;
            chk("refill_busy", busy_o, 1'b1);
            chk("refill_ready", refill_ready_o, 1'b1);
            chk("refill_cpu_ready", cpu_req_ready_o, 1'b0);
            chk("refill_index", bank_index_o, idx);
            chk("refill_wr_en", bank_wr_en_o, 16'hF << (4 * k));
            chk("refill_wr_data", bank_wr_data_o, d);
            step();
            shadow[k][idx] = d;
            refill_valid_i = 1'b0;
            if (k == bubble_after) begin
                #3;
                chk("bubble_busy", busy_o, 1'b1);
                chk("bubble_wr_en", bank_wr_en_o, 16'h0);
                step();
            end
        end
        if (nbeats == 4) begin
            #3;
            chk("refill_done", refill_done_o, 1'b1);
            chk("done_busy", busy_o, 1'b0);
            chk("done_cpu_ready", cpu_req_ready_o, 1'b1);
            exp_done++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 256; i++) begin
                ram[b][i]    = init_word(b, i);
                shadow[b][i] = init_word(b, i);
            end

        vecs[0]  = '{1'b1, 8'h12, 2'd2, 4'b0101, 32'hAABBCCDD, 16'h0500};
        vecs[1]  = '{1'b0, 8'h12, 2'd2, 4'b0000, 32'h0,        16'h0000};
        vecs[2]  = '{1'b1, 8'h13, 2'd0, 4'b1111, 32'h12345678, 16'h000F};
        vecs[3]  = '{1'b1, 8'h14, 2'd3, 4'b1000, 32'hDEADBEEF, 16'h8000};
        vecs[4]  = '{1'b1, 8'h15, 2'd1, 4'b0000, 32'hFFFFFFFF, 16'h0000};
        vecs[5]  = '{1'b0, 8'h13, 2'd0, 4'b0000, 32'h0,        16'h0000};
        vecs[6]  = '{1'b0, 8'h14, 2'd3, 4'b0000, 32'h0,        16'h0000};
        vecs[7]  = '{1'b0, 8'h15, 2'd1, 4'b0000, 32'h0,        16'h0000};
        vecs[8]  = '{1'b0, 8'h12, 2'd2, 4'b0000, 32'h0,        16'h0000};
        vecs[9]  = '{1'b0, 8'h13, 2'd0, 4'b0000, 32'h0,        16'h0000};
        vecs[10] = '{1'b0, 8'h14, 2'd3, 4'b0000, 32'h0,        16'h0000};
        vecs[11] = '{1'b0, 8'h99, 2'd1, 4'b0000, 32'h0,        16'h0000};

        // Reset with requests asserted: everything held low.
        rst_n = 1'b0;
        cpu_req_valid_i = 1'b1; cpu_req_we_i = 1'b1; cpu_req_index_i = 8'h01;
        cpu_req_bank_i = 2'd0; cpu_req_wstrb_i = 4'hF; cpu_req_wdata_i = 32'h0;
        refill_start_i = 1'b0; refill_index_i = 8'h0;
        refill_valid_i = 1'b1; refill_data_i = 32'hFFFFFFFF;
        step();
        step();
        #3;
        chk("rst_cpu_ready", cpu_req_ready_o, 1'b0);
        chk("rst_rsp_valid", cpu_rsp_valid_o, 1'b0);
        chk("rst_rsp_data", cpu_rsp_data_o, 32'h0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_refill_ready", refill_ready_o, 1'b0);
        chk("rst_done", refill_done_o, 1'b0);
        chk("rst_wr_en", bank_wr_en_o, 16'h0);
        step();
        rst_n = 1'b1;
        cpu_req_valid_i = 1'b0;
        refill_valid_i = 1'b0;
        step();

        // Table: stores, masked store, zero-strobe store, loads, then 4 back-to-back loads.
        for (int i = 0; i < 12; i++)
            cpu_op(vecs[i].we, vecs[i].idx, vecs[i].bank, vecs[i].strb,
                   vecs[i].wdata, vecs[i].exp_en);
        step();

        // Refill beat outside a fill is ignored.
        refill_valid_i = 1'b1;
        refill_data_i  = 32'hCAFEF00D;
        #3;
        chk("idle_refill_ready", refill_ready_o, 1'b0);
        chk("idle_refill_wr_en", bank_wr_en_o, 16'h0);
        step();
        refill_valid_i = 1'b0;

        // Refill 0x40 with a bubble after beat 1, then read the line back.
        refill(8'h40, 32'h11111111, 4, 1);
        step();
        for (int b = 0; b < 4; b++) cpu_op(1'b0, 8'h40, 2'(b), 4'h0, 32'h0, 16'h0);
        step();

        // Refill start wins over a simultaneous CPU load; CPU served in the done cycle.
        cpu_req_valid_i = 1'b1;
        cpu_req_we_i    = 1'b0;
        cpu_req_index_i = 8'h40;
        cpu_req_bank_i  = 2'd0;
        refill(8'h70, 32'h03030303, 4, -1);
        cpu_op(1'b0, 8'h70, 2'd3, 4'h0, 32'h0, 16'h0);
        step();

        // Reset after two beats: no done pulse, then a clean refill of the same line.
        refill(8'h50, 32'h0A0A0A0A, 2, -1);
        rst_n = 1'b0;
        refill_valid_i = 1'b1;
        refill_data_i  = 32'hBAD0BAD0;
        #3;
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_refill_ready", refill_ready_o, 1'b0);
        chk("midrst_wr_en", bank_wr_en_o, 16'h0);
        step();
        rst_n = 1'b1;
        refill_valid_i = 1'b0;
        #3;
        chk("postrst_busy", busy_o, 1'b0);
        chk("postrst_cpu_ready", cpu_req_ready_o, 1'b1);
        step();
        step();
        chk("no_done_after_reset", done_cnt, exp_done);
        refill(8'h50, 32'h0C0C0C0C, 4, -1);
        step();
        for (int b = 0; b < 4; b++) cpu_op(1'b0, 8'h50, 2'(b), 4'h0, 32'h0, 16'h0);

        // Load in the cycle before refill_start at the same index sees old data.
        cpu_op(1'b0, 8'h60, 2'd1, 4'h0, 32'h0, 16'h0);
        refill(8'h60, 32'h07070707, 4, -1);
        step();
        cpu_op(1'b0, 8'h60, 2'd1, 4'h0, 32'h0, 16'h0);

        step();
        step();
        step();
        chk("sb_drained", sb.size(), 0);
        chk("done_count", done_cnt, exp_done);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
